// File: rtl/mcpu_regfile_pkg.sv
// Shared CPU package: register-file geometry and named register numbers
// used by the multicycle CPU and its register file.
package mcpu_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int REG_COUNT  = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    // True when an address selects the hardwired zero register.
    function automatic logic isZeroReg(input logic [REG_ADDR_W-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/mcpu_regfile_wa_decoder.sv
// One-hot decoder for the register-file write address. At most one bit is
// ever set, and bit 0 never is, because register 0 can never be written.
module mcpu_regfile_wa_decoder #(
    parameter int ADDR_W = 5
) (
    input  logic                   en_i,
    input  logic [ADDR_W-1:0]      addr_i,
    output logic [(1<<ADDR_W)-1:0] onehot_o
);

    // Raise the enable of the addressed register, keep the zero register dark.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
        onehot_o[0] = 1'b0;
    end

endmodule

// File: rtl/mcpu_regfile.sv
// General-purpose register file for the multicycle CPU: 2^ADDR_W words,
// register 0 hardwired to zero, two combinational read ports with optional
// same-cycle write forwarding, and operand latches A/B that capture the
// read data on every clock edge.
module mcpu_regfile #(
    parameter int DATA_W = mcpu_regfile_pkg::DATA_W,
    parameter int ADDR_W = mcpu_regfile_pkg::REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] a_q,
    output logic [DATA_W-1:0] b_q
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  wen;
    logic              bypass1;
    logic              bypass2;

    mcpu_regfile_wa_decoder #(
        .ADDR_W (ADDR_W)
    ) u_wa_decoder (
        .en_i     (we),
        .addr_i   (wa),
        .onehot_o (wen)
    );

    // Next register contents: only the decoded register takes the write data.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = wen[i] ? wd : regs_q[i];
        end
        regs_d[0] = '0;
    end

    // Register storage; reset clears everything and wins over a pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Forwarding hits: a live write to a nonzero register that is being read.
    always_comb begin
        bypass1 = (BYPASS != 0) && we && (wa != '0) && (wa == ra1);
        bypass2 = (BYPASS != 0) && we && (wa != '0) && (wa == ra2);
    end

    // Read port 1: zero register first, then forwarded data, then storage.
    always_comb begin
        rd1 = regs_q[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (bypass1) begin
            rd1 = wd;
        end
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        rd2 = regs_q[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (bypass2) begin
            rd2 = wd;
        end
    end

    // Operand latches hold the (possibly forwarded) read data for the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= rd1;
            b_q <= rd2;
        end
    end

endmodule

// File: tb/tb_mcpu_regfile.sv
// Self-checking bench for mcpu_regfile. Two instances share the same inputs,
// one with forwarding enabled and one without, so both read behaviours are
// checked side by side on every cycle.
module tb_mcpu_regfile;
    import mcpu_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1B, rd2B, aB, bB;
    logic [31:0] rd1N, rd2N, aN, bN;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    mcpu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) uBypass (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1B), .rd2(rd2B),
        .we(we), .wa(wa), .wd(wd), .a_q(aB), .b_q(bB)
    );

    mcpu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) uNoBypass (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1N), .rd2(rd2N),
        .we(we), .wa(wa), .wd(wd), .a_q(aN), .b_q(bN)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd1B, rd2B, rd1N, rd2N;
        logic [31:0] aB, bB, aN, bN;
    } exp_t;

    exp_t        sbQ[$];
    logic [31:0] model [32];
    logic [31:0] aExpB, bExpB, aExpN, bExpN;
    int          compared = 0;
    int          mismatched = 0;
    vec_t        vecs[12];

    function automatic vec_t mkVec(input string n, input logic r, input logic w,
                                   input logic [4:0] a, input logic [31:0] d,
                                   input logic [4:0] r1, input logic [4:0] r2,
                                   input logic [31:0] x1, input logic [31:0] x2);
        vec_t v;
        v.name = n; v.rst = r; v.we = w; v.wa = a; v.wd = d;
        v.ra1 = r1; v.ra2 = r2; v.e1 = x1; v.e2 = x2;
        return v;
    endfunction

    // Stored-value read as seen without forwarding.
    function automatic logic [31:0] storedRead(input logic [4:0] ra);
        return (ra == 5'd0) ? 32'd0 : model[ra];
    endfunction

    // Read as seen with forwarding of a live write.
    function automatic logic [31:0] fwdRead(input logic [4:0] ra, input logic w,
                                            input logic [4:0] a, input logic [31:0] d);
        if (ra == 5'd0) return 32'd0;
        if (w && a != 5'd0 && a == ra) return d;
        return model[ra];
    endfunction

    task automatic compare(input string n, input string port,
                           input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s %s: got %h, expected %h", n, port, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst = v.rst; we = v.we; wa = v.wa; wd = v.wd; ra1 = v.ra1; ra2 = v.ra2;
        e.name = v.name;
        e.rd1B = v.e1;
        e.rd2B = v.e2;
        e.rd1N = storedRead(v.ra1);
        e.rd2N = storedRead(v.ra2);
        e.aB = aExpB; e.bB = bExpB; e.aN = aExpN; e.bN = bExpN;
        sbQ.push_back(e);
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sbQ.pop_front();
        compare(e.name, "rd1 bypass", rd1B, e.rd1B);
        compare(e.name, "rd2 bypass", rd2B, e.rd2B);
        compare(e.name, "rd1 nobypass", rd1N, e.rd1N);
        compare(e.name, "rd2 nobypass", rd2N, e.rd2N);
        compare(e.name, "a_q bypass", aB, e.aB);
        compare(e.name, "b_q bypass", bB, e.bB);
        compare(e.name, "a_q nobypass", aN, e.aN);
        compare(e.name, "b_q nobypass", bN, e.bN);
    endtask

    // One full cycle: drive after the edge, check mid-cycle, advance the model.
    task automatic runVector(input vec_t v);
        exp_t e;
        applyStimulus(v);
        e = sbQ[$];
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            aExpB = 32'd0; bExpB = 32'd0; aExpN = 32'd0; bExpN = 32'd0;
        end else begin
            if (v.we && v.wa != 5'd0) model[v.wa] = v.wd;
            aExpB = e.rd1B; bExpB = e.rd2B; aExpN = e.rd1N; bExpN = e.rd2N;
        end
        #1;
    endtask

    initial begin
        logic [4:0]  r1, r2, a;
        logic [31:0] d;
        logic        w;

        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        aExpB = 32'd0; bExpB = 32'd0; aExpN = 32'd0; bExpN = 32'd0;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        repeat (2) @(posedge clk);
        #1;

        //                 name          rst we wa     wd            ra1    ra2    rd1(byp)      rd2(byp)
        vecs[0]  = mkVec("wrR5",        0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mkVec("rstCycle",    1, 0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[2]  = mkVec("afterRst",    0, 0, 5'd0, 32'h0,        5'd5, 5'd5, 32'h0,        32'h0);
        vecs[3]  = mkVec("wrR8",        0, 1, 5'd8, 32'h12345678, 5'd8, 5'd8, 32'h12345678, 32'h12345678);
        vecs[4]  = mkVec("rdR8",        0, 0, 5'd0, 32'h0,        5'd8, 5'd8, 32'h12345678, 32'h12345678);
        vecs[5]  = mkVec("wrR0",        0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd8, 32'h0,        32'h12345678);
        vecs[6]  = mkVec("rdR0",        0, 0, 5'd0, 32'h0,        5'd0, 5'd8, 32'h0,        32'h12345678);
        vecs[7]  = mkVec("wrR3old",     0, 1, 5'd3, 32'h11,       5'd0, 5'd0, 32'h0,        32'h0);
        vecs[8]  = mkVec("wrR3fwd",     0, 1, 5'd3, 32'h22,       5'd3, 5'd8, 32'h22,       32'h12345678);
        vecs[9]  = mkVec("rdR3",        0, 0, 5'd0, 32'h0,        5'd3, 5'd3, 32'h22,       32'h22);
        vecs[10] = mkVec("rstWrR9",     1, 1, 5'd9, 32'hAA,       5'd9, 5'd3, 32'hAA,       32'h22);
        vecs[11] = mkVec("rdR9",        0, 0, 5'd0, 32'h0,        5'd9, 5'd3, 32'h0,        32'h0);

        for (int i = 0; i < 12; i++) runVector(vecs[i]);

        // Decoder sweep: every writable address gets its own number.
        for (int i = 1; i <= int'(REG_RA); i++) begin
            runVector(mkVec("sweepWr", 0, 1, 5'(i), 32'(i), 5'(i), 5'd0, 32'(i), 32'd0));
        end
        for (int i = 0; i < 32; i++) begin
            runVector(mkVec("sweepRd", 0, 0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 32'(i), 32'(31 - i)));
        end

        // Random traffic with forwarding expectations taken from the model.
        for (int n = 0; n < 200; n++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            runVector(mkVec("random", ($urandom_range(0, 49) == 0), w, a, d, r1, r2,
                            fwdRead(r1, w, a, d), fwdRead(r2, w, a, d)));
        end

        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", sbQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
